dfm_port_arbiter: RTL and testbench
===================================

# dfm_port_arbiter

Shares the single data-flash-memory (DFM) port between the pipelined CPU load/store stage and a secondary DMA/debug master. Per cycle, it grants the port to one requester under CPU-priority arbitration with a starvation guard. It routes the synchronous read data back to whichever master issued the read. It sits between the CPU memory stage / DMA engine and the `dfm` instance inside `mcu_v2_pipeline`.

## Interface
- `ADDR_BUS_WIDTH`, 32, address width of all ports
- `DATA_BUS_WIDTH`, 32, data width of all ports
- `MAX_CPU_RUN`, 4, consecutive CPU grants allowed while DMA is waiting (range 1..15)

- `sys_clk`  in  1  system clock; all state updates on rising edge
- `sys_rst_n`  in  1  reset, synchronous, active-low
- `cpu_req` / `dma_req`  in  1  requester wants the DFM port this cycle
- `cpu_addr` / `dma_addr`  in  ADDR_BUS_WIDTH  byte address
- `cpu_wr_en` / `dma_wr_en`  in  1  1 = write, 0 = read
- `cpu_wr_data` / `dma_wr_data`  in  DATA_BUS_WIDTH  write data
- `cpu_gnt` / `dma_gnt`  out  1  access accepted this cycle (combinational)
- `cpu_rvalid` / `dma_rvalid`  out  1  read data valid (registered)
- `cpu_rdata` / `dma_rdata`  out  DATA_BUS_WIDTH  read data
- `dfm_req_addr`  out  ADDR_BUS_WIDTH  address to DFM
- `dfm_wr_en`  out  1  DFM write strobe
- `dfm_wr_data`  out  DATA_BUS_WIDTH  DFM write data
- `dfm_rd_data`  in  DATA_BUS_WIDTH  DFM read data, valid one cycle after the address

## Operation
- **At most one grant per cycle.** `cpu_gnt & dma_gnt` is never 1.
- **Arbitration:**
  - Only CPU requesting: CPU wins.
  - Only DMA requesting: DMA wins.
  - Both requesting: CPU wins unless `run_cnt == MAX_CPU_RUN`, in which case DMA wins.
- **`run_cnt`** (4-bit):
  - Increments on each CPU grant while `dma_req` = 1.
  - Clears on any DMA grant or on any cycle with `dma_req` = 0.
  - Saturates at `MAX_CPU_RUN`.
- **DFM port muxing:**
  - `dfm_req_addr`, `dfm_wr_en` and `dfm_wr_data` come from the granted master.
  - With no grant: `dfm_wr_en` = 0, and addr/data hold the CPU inputs. Reads are harmless.
- **Read-return tracking:** register `rd_owner` is a `dfm_owner_e` with values OWN_NONE, OWN_CPU, OWN_DMA.
  - Loaded each cycle with the owner of a granted read, or OWN_NONE for a write or no grant.
  - Next cycle, `<owner>_rvalid` = 1. Both `rdata` outputs are driven from `dfm_rd_data` unconditionally; only `rvalid` qualifies them.
- **Writes:** complete in the grant cycle; no response is returned.
- **Requester rules:**
  - A requester holds req/addr/data stable until it sees its `gnt`.
  - Dropping `req` without a grant is legal (the request is withdrawn).
- **Reset values:** `run_cnt` = 0, `rd_owner` = OWN_NONE, both `rvalid` = 0, `dfm_wr_en` = 0. Grants are 0 while `sys_rst_n` = 0.
- **Reset mid-operation:** a read granted in the cycle where `sys_rst_n` is sampled low produces no `rvalid`.

## Timing
- Grant latency is 0 cycles (combinational from `req`, `run_cnt`).
- Read data latency is 1 cycle after the grant.
- Back-to-back reads from alternating masters are fully pipelined:
  - Cycle N grants CPU, cycle N+1 grants DMA.
  - `cpu_rvalid` is high in N+1; `dma_rvalid` is high in N+2.
- Worst-case DMA wait with continuous CPU traffic is `MAX_CPU_RUN` cycles. The grant comes on cycle `MAX_CPU_RUN`+1.
- Combinational path: `req` → `gnt` → `dfm_*` outputs. There is no path from `dfm_rd_data` to `gnt`.

## Structure
- Shared package `pkg_mcu_bus`:
  - `typedef enum logic [1:0] dfm_owner_e {OWN_NONE, OWN_CPU, OWN_DMA}`.
  - Constant `DFM_REGION` = 4'b0001, used by the upstream address decoders.
- One sub-module, `dfm_arb_run_counter`: the saturating `run_cnt`, with inputs `cpu_win`, `dma_pending`, `dma_win` and output `at_limit`.
- The grant logic, port mux and `rd_owner` register stay in `dfm_port_arbiter`.

## Test plan
- **CPU-only read:** `cpu_req` = 1, read, addr 0x1000_0010, DFM word 0xDEAD_BEEF → `cpu_gnt` = 1 same cycle; `cpu_rvalid` = 1 with `cpu_rdata` = 0xDEAD_BEEF next cycle; `dma_rvalid` stays 0.
- **Starvation guard:** both requesting continuously, `MAX_CPU_RUN` = 4 → grant sequence CPU, CPU, CPU, CPU, DMA, CPU×4, DMA…
- **DMA write while CPU idle:** DMA writes 0x1234_5678 to 0x1000_0040 → `dfm_wr_en` = 1 with that addr/data in the grant cycle; no `rvalid` on either side.
- **Alternating reads:** CPU reads addr A in cycle N, DMA reads addr B in N+1 → `cpu_rvalid` in N+1 with `mem[A]`, `dma_rvalid` in N+2 with `mem[B]`; never both high in the same cycle.
- **Reset mid-read:** CPU read granted in the cycle `sys_rst_n` is sampled 0 → no `cpu_rvalid` afterward; `run_cnt` = 0; the first post-reset contested cycle grants CPU.
- **Withdrawn request:** DMA raises `req` for 2 cycles while the CPU holds the port, then drops it → no `dma_gnt`; `run_cnt` clears and DMA is never granted.

Source files
------------

// File: rtl/pkg_mcu_bus.sv
// Shared MCU bus definitions: DFM read-owner encoding and region decode constant.
package pkg_mcu_bus;

  // Master that issued the read currently in flight to the DFM.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } dfm_owner_e;

  // Upper-nibble region code the upstream address decoders match for the DFM.
  localparam logic [3:0] DFM_REGION = 4'b0001;

endpackage : pkg_mcu_bus

// File: rtl/dfm_arb_run_counter.sv
// Saturating count of consecutive CPU grants taken while the DMA is waiting.
// Ports:
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   cpu_win            : CPU granted this cycle
//   dma_pending        : DMA requesting this cycle
//   dma_win            : DMA granted this cycle
//   at_limit           : registered, count has reached MAX_CPU_RUN
module dfm_arb_run_counter #(
  parameter int unsigned MAX_CPU_RUN = 4
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic cpu_win,
  input  logic dma_pending,
  input  logic dma_win,
  output logic at_limit
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(MAX_CPU_RUN);

  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_cnt_next;

  // Clear whenever the DMA is served or stops waiting; otherwise count CPU wins.
  always_comb begin
    run_cnt_next = run_cnt;
    if (dma_win || !dma_pending) begin
      run_cnt_next = '0;
    end else if (cpu_win && (run_cnt != RUN_LIMIT)) begin
      run_cnt_next = run_cnt + CNT_W'(1);
    end
  end

  // at_limit is registered alongside the count so the grant path sees a flop.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      run_cnt  <= '0;
      at_limit <= 1'b0;
    end else begin
      run_cnt  <= run_cnt_next;
      at_limit <= (run_cnt_next == RUN_LIMIT);
    end
  end

endmodule : dfm_arb_run_counter

// File: rtl/dfm_port_arbiter.sv
// Shares the single DFM port between the CPU load/store stage and a DMA/debug
// master: CPU-priority arbitration with a starvation guard, port muxing, and
// routing of the one-cycle-late read data back to the issuing master.
// Ports:
//   sys_clk, sys_rst_n                 : clock, synchronous active-low reset
//   cpu_req/addr/wr_en/wr_data         : CPU request
//   dma_req/addr/wr_en/wr_data         : DMA request
//   cpu_gnt, dma_gnt                   : combinational grants
//   cpu_rvalid/rdata, dma_rvalid/rdata : read return (rvalid registered)
//   dfm_req_addr/wr_en/wr_data         : DFM request side (combinational mux)
//   dfm_rd_data                        : DFM read data, one cycle after address
module dfm_port_arbiter
  import pkg_mcu_bus::*;
#(
  parameter int unsigned ADDR_BUS_WIDTH = 32,
  parameter int unsigned DATA_BUS_WIDTH = 32,
  parameter int unsigned MAX_CPU_RUN    = 4
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      cpu_req,
  input  logic [ADDR_BUS_WIDTH-1:0] cpu_addr,
  input  logic                      cpu_wr_en,
  input  logic [DATA_BUS_WIDTH-1:0] cpu_wr_data,
  input  logic                      dma_req,
  input  logic [ADDR_BUS_WIDTH-1:0] dma_addr,
  input  logic                      dma_wr_en,
  input  logic [DATA_BUS_WIDTH-1:0] dma_wr_data,
  output logic                      cpu_gnt,
  output logic                      dma_gnt,
  output logic                      cpu_rvalid,
  output logic [DATA_BUS_WIDTH-1:0] cpu_rdata,
  output logic                      dma_rvalid,
  output logic [DATA_BUS_WIDTH-1:0] dma_rdata,
  output logic [ADDR_BUS_WIDTH-1:0] dfm_req_addr,
  output logic                      dfm_wr_en,
  output logic [DATA_BUS_WIDTH-1:0] dfm_wr_data,
  input  logic [DATA_BUS_WIDTH-1:0] dfm_rd_data
);

  logic       at_limit;
  dfm_owner_e rd_owner;
  dfm_owner_e rd_owner_next;

  dfm_arb_run_counter #(
    .MAX_CPU_RUN (MAX_CPU_RUN)
  ) u_run_counter (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .cpu_win     (cpu_gnt),
    .dma_pending (dma_req),
    .dma_win     (dma_gnt),
    .at_limit    (at_limit)
  );

  // CPU priority, except DMA wins a contested cycle once the CPU run is at its limit.
  always_comb begin
    dma_gnt = sys_rst_n & dma_req & (~cpu_req | at_limit);
    cpu_gnt = sys_rst_n & cpu_req & ~dma_gnt;
  end

  // Port mux: DMA only when granted; otherwise CPU fields with the strobe gated.
  always_comb begin
    dfm_req_addr = cpu_addr;
    dfm_wr_data  = cpu_wr_data;
    dfm_wr_en    = cpu_gnt & cpu_wr_en;
    if (dma_gnt) begin
      dfm_req_addr = dma_addr;
      dfm_wr_data  = dma_wr_data;
      dfm_wr_en    = dma_wr_en;
    end
  end

  // Owner of the read issued this cycle; writes and idle cycles return nothing.
  always_comb begin
    rd_owner_next = OWN_NONE;
    if (cpu_gnt && !cpu_wr_en) begin
      rd_owner_next = OWN_CPU;
    end else if (dma_gnt && !dma_wr_en) begin
      rd_owner_next = OWN_DMA;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rd_owner   <= OWN_NONE;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      rd_owner   <= rd_owner_next;
      cpu_rvalid <= (rd_owner_next == OWN_CPU);
      dma_rvalid <= (rd_owner_next == OWN_DMA);
    end
  end

  // Read data fans out to both masters; rvalid alone qualifies it.
  assign cpu_rdata = dfm_rd_data;
  assign dma_rdata = dfm_rd_data;

endmodule : dfm_port_arbiter

// File: tb/tb_dfm_port_arbiter.sv
// Directed bench for dfm_port_arbiter with a behavioural one-cycle-latency DFM.
module tb_dfm_port_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        cpu_req, dma_req;
  logic [31:0] cpu_addr, dma_addr;
  logic        cpu_wr_en, dma_wr_en;
  logic [31:0] cpu_wr_data, dma_wr_data;
  logic        cpu_gnt, dma_gnt;
  logic        cpu_rvalid, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata;
  logic [31:0] dfm_req_addr;
  logic        dfm_wr_en;
  logic [31:0] dfm_wr_data;
  logic [31:0] dfm_rd_data;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [31:0] mem [logic [31:0]];

  dfm_port_arbiter #(
    .ADDR_BUS_WIDTH (32),
    .DATA_BUS_WIDTH (32),
    .MAX_CPU_RUN    (4)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .cpu_req      (cpu_req),
    .cpu_addr     (cpu_addr),
    .cpu_wr_en    (cpu_wr_en),
    .cpu_wr_data  (cpu_wr_data),
    .dma_req      (dma_req),
    .dma_addr     (dma_addr),
    .dma_wr_en    (dma_wr_en),
    .dma_wr_data  (dma_wr_data),
    .cpu_gnt      (cpu_gnt),
    .dma_gnt      (dma_gnt),
    .cpu_rvalid   (cpu_rvalid),
    .cpu_rdata    (cpu_rdata),
    .dma_rvalid   (dma_rvalid),
    .dma_rdata    (dma_rdata),
    .dfm_req_addr (dfm_req_addr),
    .dfm_wr_en    (dfm_wr_en),
    .dfm_wr_data  (dfm_wr_data),
    .dfm_rd_data  (dfm_rd_data)
  );

  always #5 sys_clk = ~sys_clk;

  // Synchronous DFM: write on strobe, read data one cycle after the address.
  always @(posedge sys_clk) begin
    if (dfm_wr_en) mem[dfm_req_addr] = dfm_wr_data;
    dfm_rd_data <= mem.exists(dfm_req_addr) ? mem[dfm_req_addr] : 32'h0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 1'b0; dma_req = 1'b0;
    cpu_wr_en = 1'b0; dma_wr_en = 1'b0;
  endtask

  initial begin
    logic exp_dma;
    sys_rst_n = 1'b0;
    idle();
    cpu_addr = 32'h0; dma_addr = 32'h0;
    cpu_wr_data = 32'h0; dma_wr_data = 32'h0;
    mem[32'h1000_0010] = 32'hDEAD_BEEF;
    mem[32'h1000_0100] = 32'h1111_AAAA;
    mem[32'h1000_0200] = 32'h2222_BBBB;

    // Reset state; grants suppressed while reset is asserted
    tick(); tick();
    cpu_req = 1'b1; dma_req = 1'b1;
    #1;
    chk("rst_cpu_gnt", 64'(cpu_gnt), 64'd0);
    chk("rst_dma_gnt", 64'(dma_gnt), 64'd0);
    chk("rst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
    chk("rst_dma_rvalid", 64'(dma_rvalid), 64'd0);
    chk("rst_dfm_wr_en", 64'(dfm_wr_en), 64'd0);
    idle();
    tick();
    sys_rst_n = 1'b1;
    tick();

    // CPU-only read
    cpu_req = 1'b1; cpu_addr = 32'h1000_0010; cpu_wr_en = 1'b0;
    #1;
    chk("t1_cpu_gnt", 64'(cpu_gnt), 64'd1);
    chk("t1_dma_gnt", 64'(dma_gnt), 64'd0);
    chk("t1_addr", 64'(dfm_req_addr), 64'h1000_0010);
    tick();
    idle();
    #1;
    chk("t1_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    chk("t1_cpu_rdata", 64'(cpu_rdata), 64'hDEAD_BEEF);
    chk("t1_dma_rvalid", 64'(dma_rvalid), 64'd0);
    tick();

    // Starvation guard: C C C C D C C C C D
    cpu_req = 1'b1; dma_req = 1'b1;
    cpu_addr = 32'h1000_0010; dma_addr = 32'h1000_0100;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_dma = (i == 4) || (i == 9);
      chk($sformatf("starve_dma_gnt[%0d]", i), 64'(dma_gnt), 64'(exp_dma));
      chk($sformatf("starve_cpu_gnt[%0d]", i), 64'(cpu_gnt), 64'(!exp_dma));
      tick();
    end
    idle();
    tick();

    // DMA write while CPU idle
    dma_req = 1'b1; dma_wr_en = 1'b1;
    dma_addr = 32'h1000_0040; dma_wr_data = 32'h1234_5678;
    #1;
    chk("t3_dma_gnt", 64'(dma_gnt), 64'd1);
    chk("t3_wr_en", 64'(dfm_wr_en), 64'd1);
    chk("t3_addr", 64'(dfm_req_addr), 64'h1000_0040);
    chk("t3_wdata", 64'(dfm_wr_data), 64'h1234_5678);
    tick();
    idle();
    #1;
    chk("t3_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
    chk("t3_dma_rvalid", 64'(dma_rvalid), 64'd0);
    chk("t3_mem", 64'(mem.exists(32'h1000_0040) ? mem[32'h1000_0040] : 32'h0), 64'h1234_5678);
    tick();

    // Alternating reads: CPU in N, DMA in N+1
    cpu_req = 1'b1; cpu_addr = 32'h1000_0100;
    #1;
    chk("t4_cpu_gnt", 64'(cpu_gnt), 64'd1);
    tick();
    cpu_req = 1'b0;
    dma_req = 1'b1; dma_addr = 32'h1000_0200;
    #1;
    chk("t4_dma_gnt", 64'(dma_gnt), 64'd1);
    chk("t4_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    chk("t4_cpu_rdata", 64'(cpu_rdata), 64'h1111_AAAA);
    chk("t4_dma_rvalid_n1", 64'(dma_rvalid), 64'd0);
    tick();
    idle();
    #1;
    chk("t4_dma_rvalid", 64'(dma_rvalid), 64'd1);
    chk("t4_dma_rdata", 64'(dma_rdata), 64'h2222_BBBB);
    chk("t4_cpu_rvalid_n2", 64'(cpu_rvalid), 64'd0);
    tick();

    // Reset mid-read after the CPU run has reached its limit
    cpu_req = 1'b1; dma_req = 1'b1;
    cpu_addr = 32'h1000_0010; dma_addr = 32'h1000_0200;
    for (int i = 0; i < 4; i++) tick();
    sys_rst_n = 1'b0;
    #1;
    chk("t5_cpu_gnt_in_rst", 64'(cpu_gnt), 64'd0);
    tick();
    sys_rst_n = 1'b1;
    #1;
    chk("t5_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
    chk("t5_run_cnt", 64'(dut.u_run_counter.run_cnt), 64'd0);
    chk("t5_first_cpu_gnt", 64'(cpu_gnt), 64'd1);
    chk("t5_first_dma_gnt", 64'(dma_gnt), 64'd0);
    tick();
    idle();
    tick();

    // Withdrawn DMA request while CPU holds the port
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("t6_dma_gnt[%0d]", i), 64'(dma_gnt), 64'd0);
      tick();
    end
    dma_req = 1'b0;
    #1;
    chk("t6_dma_gnt_drop", 64'(dma_gnt), 64'd0);
    tick();
    #1;
    chk("t6_run_cnt", 64'(dut.u_run_counter.run_cnt), 64'd0);
    chk("t6_cpu_gnt", 64'(cpu_gnt), 64'd1);
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Mutual exclusion of grants, sampled every cycle
  always @(negedge sys_clk) begin
    if (cpu_gnt && dma_gnt) begin
      n_chk++;
      $display("FAIL both_gnt: got cpu_gnt=1 dma_gnt=1 expected at most one");
    end
    if (cpu_rvalid && dma_rvalid) begin
      n_chk++;
      $display("FAIL both_rvalid: got cpu_rvalid=1 dma_rvalid=1 expected at most one");
    end
  end

endmodule : tb_dfm_port_arbiter
